// File: rtl/sync_fifo_flags_if.sv
// Interface bundling the producer/consumer side of sync_fifo_flags.
//   master : producer/consumer view (drives w_enb, r_enb, din, clr_err)
//   slave  : FIFO view (drives read data, valid, level flags, count and error flags)
// DEPTH and WIDTH must match the parameters of the attached FIFO.
interface sync_fifo_flags_if #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 16
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic             w_enb;
  logic             r_enb;
  logic [WIDTH-1:0] din;
  logic             clr_err;
  logic [WIDTH-1:0] dout;
  logic             rd_valid;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             almost_empty;
  logic [CW-1:0]    count;
  logic             overflow;
  logic             underflow;

  modport master (
    output w_enb, r_enb, din, clr_err,
    input  dout, rd_valid, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  w_enb, r_enb, din, clr_err,
    output dout, rd_valid, full, empty, almost_full, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_flags.sv
// Synchronous FIFO with programmable almost-full/almost-empty thresholds, occupancy count,
// sticky overflow/underflow flags and selectable first-word-fall-through read mode.
// Ports:
//   clk    : rising-edge clock
//   reset  : asynchronous active-low reset
//   bus    : sync_fifo_flags_if.slave
//            in : w_enb, r_enb, din, clr_err
//            out: dout, rd_valid, full, empty, almost_full, almost_empty, count,
//                 overflow, underflow
module sync_fifo_flags #(
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned AF_LEVEL = DEPTH - 2,
  parameter int unsigned AE_LEVEL = 1,
  parameter bit          FWFT     = 1'b0
) (
  input logic              clk,
  input logic              reset,
  sync_fifo_flags_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  // Elaboration-time parameter legality checks.
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $fatal(1, "sync_fifo_flags: DEPTH must be a power of 2 and >= 2");
  end
  if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
    $fatal(1, "sync_fifo_flags: AF_LEVEL must be in 1..DEPTH");
  end
  if (AE_LEVEL > DEPTH - 1) begin : g_bad_ae
    $fatal(1, "sync_fifo_flags: AE_LEVEL must be in 0..DEPTH-1");
  end

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             overflow_q, underflow_q;
  logic             full, empty;
  logic             wr_acc, rd_acc;

  // Flags decode from the registered count, so they move on the same edge as count.
  always_comb begin
    full   = (count_q == CW'(DEPTH));
    empty  = (count_q == '0);
    wr_acc = bus.w_enb & ~full;
    rd_acc = bus.r_enb & ~empty;
  end

  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.almost_full  = (count_q >= CW'(AF_LEVEL));
  assign bus.almost_empty = (count_q <= CW'(AE_LEVEL));
  assign bus.count        = count_q;
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_acc) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({wr_acc, rd_acc})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      // A new error in the same cycle as clr_err wins over the clear.
      overflow_q  <= (bus.w_enb & full)  | (overflow_q  & ~bus.clr_err);
      underflow_q <= (bus.r_enb & empty) | (underflow_q & ~bus.clr_err);
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_ptr_q] <= bus.din;
  end

  if (FWFT) begin : g_fwft
    // Head of queue is always visible; a pop exposes the next word on the same edge.
    assign bus.dout     = mem_q[rd_ptr_q];
    assign bus.rd_valid = ~empty;
  end else begin : g_std
    logic [WIDTH-1:0] dout_q;
    logic             rd_valid_q;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        dout_q     <= '0;
        rd_valid_q <= 1'b0;
      end else begin
        rd_valid_q <= rd_acc;
        if (rd_acc) dout_q <= mem_q[rd_ptr_q];
      end
    end

    assign bus.dout     = dout_q;
    assign bus.rd_valid = rd_valid_q;
  end
endmodule

// File: tb/tb_sync_fifo_flags.sv
module tb_sync_fifo_flags;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned WIDTH = 16;
  localparam int unsigned AF    = 6;
  localparam int unsigned AE    = 1;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  sync_fifo_flags_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) bus0 ();
  sync_fifo_flags_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) bus1 ();

  sync_fifo_flags #(
    .DEPTH(DEPTH), .WIDTH(WIDTH), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(1'b0)
  ) dut0 (
    .clk(clk), .reset(reset), .bus(bus0)
  );

  sync_fifo_flags #(
    .DEPTH(DEPTH), .WIDTH(WIDTH), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(1'b1)
  ) dut1 (
    .clk(clk), .reset(reset), .bus(bus1)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: plain queue of stored words plus sticky flags.
  logic [WIDTH-1:0] model [$];
  logic [WIDTH-1:0] exp_q [$];   // scoreboard for standard-mode read data
  logic [WIDTH-1:0] last_rd = '0;
  bit               m_ov = 0, m_ud = 0, exp_rv = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_state();
    int cnt;
    cnt = model.size();
    chk("count0",    32'(bus0.count), 32'(cnt));
    chk("count1",    32'(bus1.count), 32'(cnt));
    chk("full0",     32'(bus0.full), 32'(cnt == DEPTH));
    chk("full1",     32'(bus1.full), 32'(cnt == DEPTH));
    chk("empty0",    32'(bus0.empty), 32'(cnt == 0));
    chk("empty1",    32'(bus1.empty), 32'(cnt == 0));
    chk("afull0",    32'(bus0.almost_full), 32'(cnt >= AF));
    chk("aempty0",   32'(bus0.almost_empty), 32'(cnt <= AE));
    chk("afull1",    32'(bus1.almost_full), 32'(cnt >= AF));
    chk("aempty1",   32'(bus1.almost_empty), 32'(cnt <= AE));
    chk("overflow0", 32'(bus0.overflow), 32'(m_ov));
    chk("underflow0", 32'(bus0.underflow), 32'(m_ud));
    chk("overflow1", 32'(bus1.overflow), 32'(m_ov));
    chk("underflow1", 32'(bus1.underflow), 32'(m_ud));
    chk("rd_valid0", 32'(bus0.rd_valid), 32'(exp_rv));
    chk("dout0_hold", 32'(bus0.dout), 32'(last_rd));
    chk("rd_valid1", 32'(bus1.rd_valid), 32'(cnt != 0));
    if (cnt != 0) chk("dout1_head", 32'(bus1.dout), 32'(model[0]));
  endtask

  // Drive one clock of stimulus, advance the model, then check after the edge.
  task automatic cycle(input bit w, input bit r, input logic [WIDTH-1:0] d, input bit clr);
    bit m_full, m_empty, wacc, racc;
    bus0.w_enb = w; bus0.r_enb = r; bus0.din = d; bus0.clr_err = clr;
    bus1.w_enb = w; bus1.r_enb = r; bus1.din = d; bus1.clr_err = clr;
    m_full  = (model.size() == DEPTH);
    m_empty = (model.size() == 0);
    wacc    = w && !m_full;
    racc    = r && !m_empty;
    m_ov    = (w && m_full) || (m_ov && !clr);
    m_ud    = (r && m_empty) || (m_ud && !clr);
    exp_rv  = racc;
    if (racc) begin
      last_rd = model.pop_front();
      exp_q.push_back(last_rd);
    end
    if (wacc) model.push_back(d);
    @(posedge clk);
    #1;
    check_state();
  endtask

  // Monitor: every standard-mode read-valid pulse must match the next scoreboard entry.
  always @(negedge clk) begin
    if (reset && bus0.rd_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected actual=%0h expected=none at %0t", bus0.dout, $time);
      end else begin
        chk("sb_dout", 32'(bus0.dout), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    logic [WIDTH-1:0] d;
    bus0.w_enb = 0; bus0.r_enb = 0; bus0.din = '0; bus0.clr_err = 0;
    bus1.w_enb = 0; bus1.r_enb = 0; bus1.din = '0; bus1.clr_err = 0;

    // Reset state.
    @(posedge clk); #1;
    check_state();
    reset = 1'b1;

    // Fill 0x0001..0x0008, then overflow attempts, then clear.
    for (int i = 1; i <= 8; i++) cycle(1, 0, 16'(i), 0);
    cycle(1, 0, 16'hDEAD, 0);
    cycle(1, 0, 16'hDEAD, 0);
    cycle(0, 0, '0, 1);

    // Drain and underflow.
    for (int i = 0; i < 8; i++) cycle(0, 1, '0, 0);
    cycle(0, 1, '0, 0);
    cycle(0, 1, '0, 0);
    chk("dout_after_underflow", 32'(bus0.dout), 32'h0008);
    cycle(0, 0, '0, 1);

    // Simultaneous read/write with 3 preloaded words.
    for (int i = 0; i < 3; i++) cycle(1, 0, 16'h0011 + 16'(i), 0);
    for (int i = 0; i < 4; i++) cycle(1, 1, 16'h00A0 + 16'(i), 0);
    for (int i = 0; i < 3; i++) cycle(0, 1, '0, 0);
    cycle(1, 1, 16'h00B0, 0);   // empty: write only, underflow
    cycle(0, 1, '0, 1);

    // Wrap-around: alternate write/read.
    d = 16'h0100;
    for (int i = 0; i < 20; i++) begin
      if (i % 2 == 0) begin
        cycle(1, 0, d, 0);
        d = d + 1'b1;
      end else begin
        cycle(0, 1, '0, 0);
      end
    end

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom),
            ($urandom_range(0, 15) == 0));
    end

    // FWFT visibility, then asynchronous reset with 4 words stored.
    while (model.size() != 0) cycle(0, 1, '0, 0);
    cycle(0, 0, '0, 1);
    cycle(1, 0, 16'h1111, 0);
    chk("fwft_dout", 32'(bus1.dout), 32'h1111);
    chk("fwft_valid", 32'(bus1.rd_valid), 32'h1);
    for (int i = 0; i < 3; i++) cycle(1, 0, 16'h2220 + 16'(i), 0);
    cycle(0, 0, '0, 0);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_count0", 32'(bus0.count), 32'h0);
    chk("arst_count1", 32'(bus1.count), 32'h0);
    chk("arst_empty0", 32'(bus0.empty), 32'h1);
    chk("arst_empty1", 32'(bus1.empty), 32'h1);
    chk("arst_valid0", 32'(bus0.rd_valid), 32'h0);
    chk("arst_valid1", 32'(bus1.rd_valid), 32'h0);
    chk("arst_dout0", 32'(bus0.dout), 32'h0);
    model.delete();
    exp_q.delete();
    m_ov = 0; m_ud = 0; exp_rv = 0; last_rd = '0;
    @(posedge clk); #1;
    check_state();
    reset = 1'b1;

    // Post-reset traffic.
    for (int i = 0; i < 40; i++) begin
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom), 0);
    end
    cycle(0, 0, '0, 0);
    cycle(0, 0, '0, 0);
    chk("sb_drained", 32'(exp_q.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
